// File: rtl/pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_controller
// Description : Pong match sequencer. Tracks both scores, paces serve,
//               countdown and post-point pause using frame ticks, detects the
//               winner and gates the ball datapath (hold / enable).
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_controller #(
  parameter int WIN_SCORE        = 7,
  parameter int SCORE_W          = 4,
  parameter int COUNTDOWN_FRAMES = 90,
  parameter int PAUSE_FRAMES     = 60
) (
  input  logic               CLOCK_25,
  input  logic               RESET_N,
  input  logic               frame_tick,
  input  logic               miss_p1,
  input  logic               miss_p2,
  input  logic               button_p1,
  input  logic               button_p2,
  output logic               ball_hold,
  output logic               ball_enable,
  output logic               serve_left,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               point_pulse,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int C_MAX_FRAMES = (COUNTDOWN_FRAMES > PAUSE_FRAMES) ? COUNTDOWN_FRAMES : PAUSE_FRAMES;
  localparam int C_CNT_W      = $clog2(C_MAX_FRAMES + 1);

  localparam logic [C_CNT_W-1:0] C_CD_LOAD    = C_CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [C_CNT_W-1:0] C_PAUSE_LOAD = C_CNT_W'(PAUSE_FRAMES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
  localparam logic [SCORE_W-1:0] C_WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] C_SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_RALLY      = 3'd2,
    ST_PAUSE      = 3'd3,
    ST_SERVE_WAIT = 3'd4,
    ST_OVER       = 3'd5
  } state_t;

  state_t             r_state, w_next_state;
  logic [C_CNT_W-1:0] r_cnt, w_next_cnt;
  logic [SCORE_W-1:0] r_score_p1, w_next_score_p1;
  logic [SCORE_W-1:0] r_score_p2, w_next_score_p2;
  logic               r_serve_left, w_next_serve_left;
  logic [1:0]         r_winner, w_next_winner;
  logic               r_point_pulse, w_next_point_pulse;
  logic               r_ball_hold, r_ball_enable;

  logic [SCORE_W-1:0] w_inc_p1, w_inc_p2;
  logic               w_serve_btn;

  assign w_inc_p1 = r_score_p1 + C_SCORE_ONE;
  assign w_inc_p2 = r_score_p2 + C_SCORE_ONE;
  // Only the player who conceded the last point may serve.
  assign w_serve_btn = r_serve_left ? button_p1 : button_p2;

  // State, counter and all outputs are registered from their next values.
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_score_p1    <= '0;
      r_score_p2    <= '0;
      r_serve_left  <= 1'b0;
      r_winner      <= 2'b00;
      r_point_pulse <= 1'b0;
      r_ball_hold   <= 1'b1;
      r_ball_enable <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_score_p1    <= w_next_score_p1;
      r_score_p2    <= w_next_score_p2;
      r_serve_left  <= w_next_serve_left;
      r_winner      <= w_next_winner;
      r_point_pulse <= w_next_point_pulse;
      r_ball_hold   <= (w_next_state != ST_RALLY);
      r_ball_enable <= (w_next_state == ST_RALLY);
    end
  end

  // Next-state, frame counter, scoring and winner decision.
  always_comb begin
    w_next_state       = r_state;
    w_next_cnt         = r_cnt;
    w_next_score_p1    = r_score_p1;
    w_next_score_p2    = r_score_p2;
    w_next_serve_left  = r_serve_left;
    w_next_winner      = r_winner;
    w_next_point_pulse = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (button_p1 || button_p2) begin
          w_next_score_p1   = '0;
          w_next_score_p2   = '0;
          w_next_winner     = 2'b00;
          w_next_serve_left = 1'b0;
          w_next_cnt        = C_CD_LOAD;
          w_next_state      = ST_COUNTDOWN;
        end
      end

      ST_COUNTDOWN: begin
        if (frame_tick) begin
          if (r_cnt <= C_CNT_ONE) begin
            w_next_cnt   = '0;
            w_next_state = ST_RALLY;
          end else begin
            w_next_cnt = r_cnt - C_CNT_ONE;
          end
        end
      end

      ST_RALLY: begin
        // miss_p1 has priority when both misses arrive together.
        if (miss_p1) begin
          w_next_score_p2    = w_inc_p2;
          w_next_serve_left  = 1'b1;
          w_next_point_pulse = 1'b1;
          if (w_inc_p2 == C_WIN) begin
            w_next_winner = 2'b10;
            w_next_cnt    = '0;
            w_next_state  = ST_OVER;
          end else begin
            w_next_cnt   = C_PAUSE_LOAD;
            w_next_state = ST_PAUSE;
          end
        end else if (miss_p2) begin
          w_next_score_p1    = w_inc_p1;
          w_next_serve_left  = 1'b0;
          w_next_point_pulse = 1'b1;
          if (w_inc_p1 == C_WIN) begin
            w_next_winner = 2'b01;
            w_next_cnt    = '0;
            w_next_state  = ST_OVER;
          end else begin
            w_next_cnt   = C_PAUSE_LOAD;
            w_next_state = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        if (frame_tick) begin
          if (r_cnt <= C_CNT_ONE) begin
            w_next_cnt   = '0;
            w_next_state = ST_SERVE_WAIT;
          end else begin
            w_next_cnt = r_cnt - C_CNT_ONE;
          end
        end
      end

      ST_SERVE_WAIT: begin
        if (w_serve_btn) begin
          w_next_cnt   = C_CD_LOAD;
          w_next_state = ST_COUNTDOWN;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign ball_hold   = r_ball_hold;
  assign ball_enable = r_ball_enable;
  assign serve_left  = r_serve_left;
  assign score_p1    = r_score_p1;
  assign score_p2    = r_score_p2;
  assign point_pulse = r_point_pulse;
  assign winner      = r_winner;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_controller
// Description : Directed self-checking bench for pong_match_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_controller;

  localparam int C_CD    = 90;
  localparam int C_PAUSE = 60;

  logic       CLOCK_25 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       frame_tick = 1'b0;
  logic       miss_p1 = 1'b0;
  logic       miss_p2 = 1'b0;
  logic       button_p1 = 1'b0;
  logic       button_p2 = 1'b0;
  logic       ball_hold, ball_enable, serve_left, point_pulse;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  pong_match_controller #(
    .WIN_SCORE(7), .SCORE_W(4), .COUNTDOWN_FRAMES(C_CD), .PAUSE_FRAMES(C_PAUSE)
  ) u_dut (
    .CLOCK_25   (CLOCK_25),
    .RESET_N    (RESET_N),
    .frame_tick (frame_tick),
    .miss_p1    (miss_p1),
    .miss_p2    (miss_p2),
    .button_p1  (button_p1),
    .button_p2  (button_p2),
    .ball_hold  (ball_hold),
    .ball_enable(ball_enable),
    .serve_left (serve_left),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .point_pulse(point_pulse),
    .winner     (winner),
    .state      (state)
  );

  // 25 MHz-style free-running clock (period 10 time units).
  always #5 CLOCK_25 = ~CLOCK_25;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 unit after the edge.
  task automatic step(input logic ft, input logic m1, input logic m2,
                      input logic b1, input logic b2);
    frame_tick = ft; miss_p1 = m1; miss_p2 = m2; button_p1 = b1; button_p2 = b2;
    @(posedge CLOCK_25);
    #1;
    frame_tick = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0; button_p1 = 1'b0; button_p2 = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_sp1"},   int'(score_p1), 0);
    check({tag, "_sp2"},   int'(score_p2), 0);
    check({tag, "_win"},   int'(winner), 0);
    check({tag, "_serve"}, int'(serve_left), 0);
    check({tag, "_pulse"}, int'(point_pulse), 0);
    check({tag, "_hold"},  int'(ball_hold), 1);
    check({tag, "_en"},    int'(ball_enable), 0);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("rst");
    RESET_N = 1'b1;

    // Start from IDLE with button_p2; coincident tick does not count.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("start_state", int'(state), 1);
    check("start_hold", int'(ball_hold), 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("cd_ignore_state", int'(state), 1);
    check("cd_ignore_sp2", int'(score_p2), 0);
    run_ticks(C_CD - 1);
    check("cd89_state", int'(state), 1);
    check("cd89_en", int'(ball_enable), 0);
    run_ticks(1);
    check("cd90_state", int'(state), 2);
    check("cd90_en", int'(ball_enable), 1);
    check("cd90_hold", int'(ball_hold), 0);
    check("cd90_sp1", int'(score_p1), 0);

    // Point for P1
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pt1_sp1", int'(score_p1), 1);
    check("pt1_pulse", int'(point_pulse), 1);
    check("pt1_state", int'(state), 3);
    check("pt1_hold", int'(ball_hold), 1);
    check("pt1_en", int'(ball_enable), 0);
    check("pt1_serve", int'(serve_left), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pt1_pulse_off", int'(point_pulse), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_miss_sp2", int'(score_p2), 0);
    run_ticks(C_PAUSE - 1);
    check("pause59_state", int'(state), 3);
    run_ticks(1);
    check("pause60_state", int'(state), 4);

    // serve_left=0: P1 button ignored, P2 accepted
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sw0_b1_ign", int'(state), 4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sw0_b2_acc", int'(state), 1);
    run_ticks(C_CD);
    check("rally2_state", int'(state), 2);

    // Both misses in the same cycle: only P2 scores
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("both_sp2", int'(score_p2), 1);
    check("both_sp1", int'(score_p1), 1);
    check("both_serve", int'(serve_left), 1);
    check("both_state", int'(state), 3);
    run_ticks(C_PAUSE);
    check("sw1_state", int'(state), 4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sw1_b2_ign", int'(state), 4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sw1_b1_acc", int'(state), 1);
    run_ticks(C_CD);

    // Bring P1 to 6 points
    repeat (5) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_ticks(C_PAUSE);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_ticks(C_CD);
    end
    check("pre_win_sp1", int'(score_p1), 6);
    check("pre_win_state", int'(state), 2);

    // Winning point
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("win_sp1", int'(score_p1), 7);
    check("win_state", int'(state), 5);
    check("win_winner", int'(winner), 1);
    check("win_pulse", int'(point_pulse), 1);
    check("win_hold", int'(ball_hold), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("over_miss_sp2", int'(score_p2), 1);
    check("over_miss_state", int'(state), 5);
    check("over_winner_frozen", int'(winner), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_state", int'(state), 1);
    check("restart_sp1", int'(score_p1), 0);
    check("restart_sp2", int'(score_p2), 0);
    check("restart_winner", int'(winner), 0);

    // Reset mid-countdown
    run_ticks(10);
    RESET_N = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("rst_cd");
    RESET_N = 1'b1;

    // P2 wins the whole match, then reset in OVER
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_ticks(C_CD);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 6) begin
        run_ticks(C_PAUSE);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_ticks(C_CD);
      end
    end
    check("p2win_state", int'(state), 5);
    check("p2win_winner", int'(winner), 2);
    check("p2win_sp2", int'(score_p2), 7);
    check("p2win_serve", int'(serve_left), 1);
    RESET_N = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("rst_over");
    RESET_N = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
